// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    // One buffered fetch: instruction word plus the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with flush; no bypass path.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_data,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head_c,
    output logic [CNT_W-1:0]   count,
    output logic               full_c,
    output logic               empty_c
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign empty_c = (count == '0);
    assign full_c  = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty_c;
    assign head_c  = mem[rd_ptr];

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

    // A push that finds no free slot would overwrite a live entry.
    assert property (@(posedge clk) disable iff (rst)
        !(push && full_c && !do_pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, response buffer, redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  resp_pc;
    logic [XLEN-1:0]  redirect_target;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [SUM_W-1:0] credit_used;
    logic             fifo_full;
    logic             fifo_empty;
    logic             grant;
    logic             push;
    logic             pop;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // Requests are capped so every in-flight word is guaranteed a buffer slot.
    assign credit_used     = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign imem_req        = !rst && !redirect_valid && (credit_used < SUM_W'(FIFO_DEPTH));
    assign imem_addr       = pc;
    assign grant           = imem_req && imem_gnt;
    assign redirect_target = align_word(redirect_pc);

    // Responses still owed to a flushed stream are dropped; a redirect drops this cycle's too.
    assign push       = imem_rvalid && (discard == '0) && !redirect_valid;
    assign pop        = instr_valid && instr_ready && !redirect_valid;
    assign push_entry = '{pc: resp_pc, instr: imem_rdata};

    assign instr_valid = !fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    // PC, response-address tracker and in-flight/discard counters.
    // Kept responses are always sequential from the last reset or redirect,
    // so a single running address stands in for a per-request tag queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
            if (redirect_valid) begin
                pc      <= redirect_target;
                resp_pc <= redirect_target;
                discard <= outstanding - CNT_W'(imem_rvalid);
            end else begin
                if (grant) begin
                    pc <= pc + PC_INC;
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_INC;
                end
                if (imem_rvalid && (discard != '0)) begin
                    discard <= discard - CNT_W'(1);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_c    (head),
        .count     (fifo_count),
        .full_c    (fifo_full),
        .empty_c   (fifo_empty)
    );

    // The credit cap must make an overflowing push impossible.
    assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven streaming plus multi-cycle corner sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int          checks = 0;
    int          errors = 0;
    logic        mem_hold;
    logic [31:0] rsp_q[$];

    typedef struct {
        logic        gnt;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[8];

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: answers in order, one cycle after grant, data = ~address.
    task automatic settle();
        if (!mem_hold && rsp_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~rsp_q.pop_front();
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    task automatic tick();
        if (imem_req && imem_gnt) rsp_q.push_back(imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        instr_ready    = 1'b0;
        mem_hold       = 1'b0;
        rsp_q.delete();
        #1;
        chk("rst_req",   32'(imem_req),    32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr,            32'h0);
        chk("rst_ipc",   instr_pc,         32'h0);
        chk("rst_addr",  imem_addr,        32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int          grants;
        int          popped;
        logic [31:0] exp_next;
        logic        seen;

        // gnt, rdy, exp_req, exp_addr, exp_valid, exp_pc
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h00};

        // Streaming from reset with immediate grants and one-cycle responses
        do_reset();
        foreach (vecs[i]) begin
            imem_gnt    = vecs[i].gnt;
            instr_ready = vecs[i].rdy;
            settle();
            chk($sformatf("v%0d_req", i),   32'(imem_req),    32'(vecs[i].exp_req));
            chk($sformatf("v%0d_addr", i),  imem_addr,        vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_ipc", i),   instr_pc, vecs[i].exp_pc);
                chk($sformatf("v%0d_instr", i), instr,    ~vecs[i].exp_pc);
            end
            tick();
        end

        // Decoder stalled: credits cap grants at two, head holds still
        do_reset();
        imem_gnt    = 1'b1;
        instr_ready = 1'b0;
        grants      = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            if (imem_req && imem_gnt) grants++;
            if (i >= 2) begin
                chk("stall_valid", 32'(instr_valid), 32'h1);
                chk("stall_ipc",   instr_pc,         32'h0);
                chk("stall_instr", instr,            32'hFFFF_FFFF);
            end
            tick();
        end
        chk("stall_grants", 32'(grants),   32'd2);
        chk("stall_req",    32'(imem_req), 32'h0);
        instr_ready = 1'b1;
        exp_next    = 32'h0;
        popped      = 0;
        for (int n = 0; n < 20 && popped < 4; n++) begin
            settle();
            if (instr_valid) begin
                chk("drain_ipc",   instr_pc, exp_next);
                chk("drain_instr", instr,    ~exp_next);
                exp_next = exp_next + 32'd4;
                popped++;
            end
            tick();
        end
        chk("drain_count", 32'(popped), 32'd4);

        // Grant withheld: address held, single grant advances by one word
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        imem_gnt       = 1'b1;
        settle();
        chk("redir_req_low", 32'(imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0;
        imem_gnt       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("nogrant_req",  32'(imem_req), 32'h1);
            chk("nogrant_addr", imem_addr,     32'h10);
            tick();
        end
        imem_gnt = 1'b1;
        settle();
        chk("grant_addr", imem_addr, 32'h10);
        tick();
        imem_gnt = 1'b0;
        settle();
        chk("after_grant_addr", imem_addr, 32'h14);
        tick();

        // Redirect with two fetches in flight: both old responses dropped
        do_reset();
        mem_hold    = 1'b1;
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            tick();
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        settle();
        chk("redir2_req", 32'(imem_req), 32'h0);
        tick();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        seen           = 1'b0;
        grants         = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            settle();
            if (n == 0) chk("redir2_addr", imem_addr, 32'h200);
            if (imem_req && imem_gnt && grants == 0) begin
                chk("redir2_first_gnt", imem_addr, 32'h200);
                grants++;
            end
            if (instr_valid) begin
                chk("redir2_ipc",   instr_pc, 32'h200);
                chk("redir2_instr", instr,    ~32'h200);
                seen = 1'b1;
            end
            tick();
        end
        chk("redir2_seen", 32'(seen), 32'h1);

        // Redirect coinciding with response and pop: nothing stale survives
        do_reset();
        mem_hold    = 1'b1;
        imem_gnt    = 1'b1;
        instr_ready = 1'b0;
        settle(); tick();
        settle(); tick();
        mem_hold = 1'b0;
        settle(); tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        instr_ready    = 1'b1;
        settle();
        chk("coll_valid_before", 32'(instr_valid), 32'h1);
        chk("coll_ipc_before",   instr_pc,         32'h0);
        tick();
        redirect_valid = 1'b0;
        settle();
        chk("coll_valid_c1", 32'(instr_valid), 32'h0);
        chk("coll_req_c1",   32'(imem_req),    32'h1);
        chk("coll_addr_c1",  imem_addr,        32'h300);
        tick();
        settle();
        chk("coll_valid_c2", 32'(instr_valid), 32'h0);
        tick();
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            settle();
            if (instr_valid) begin
                chk("coll_ipc", instr_pc, 32'h300);
                seen = 1'b1;
            end
            tick();
        end
        chk("coll_seen", 32'(seen), 32'h1);

        // PC wrap at top of address space, then async reset mid-stream
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        imem_gnt       = 1'b1;
        instr_ready    = 1'b1;
        settle(); tick();
        redirect_valid = 1'b0;
        settle();
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        tick();
        settle();
        chk("wrap_addr1", imem_addr, 32'h0);
        tick();
        settle();
        chk("wrap_ipc0", instr_pc, 32'hFFFF_FFFC);
        tick();
        settle();
        chk("wrap_ipc1",  instr_pc,         32'h0);
        chk("pre_rst_req", 32'(imem_req),   32'h1);
        chk("pre_rst_vld", 32'(instr_valid), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_req",   32'(imem_req),    32'h0);
        chk("async_rst_valid", 32'(instr_valid), 32'h0);
        chk("async_rst_addr",  imem_addr,        32'h0);
        rsp_q.delete();
        imem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
